// File: rtl/reg_cmd_ctrl_pkg.sv
// Shared types and constants for the register-file command controller.
package reg_cmd_ctrl_pkg;

  // Frame-sequencing states
  typedef enum logic [2:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdWait,
    StTxSend
  } state_e;

  localparam logic [7:0] CMD_WR_DEF   = 8'hAA;
  localparam logic [7:0] CMD_RD_DEF   = 8'hBB;
  localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

  // True when every bit at or above position lsb is zero.
  // Callers zero-extend their operand to 32 bits, so any byte width up to 32 works.
  function automatic logic upper_bits_zero(input logic [31:0] value, input int unsigned lsb);
    return (value >> lsb) == 32'd0;
  endfunction

endpackage

// File: rtl/reg_cmd_ctrl.sv
// Byte-command controller: decodes UART write/read frames into register-file
// accesses and returns read data (or an error byte) to the UART transmitter.
module reg_cmd_ctrl
  import reg_cmd_ctrl_pkg::*;
#(
  parameter int unsigned     DATA     = 8,
  parameter int unsigned     ADD      = 4,
  parameter logic [DATA-1:0] CMD_WR   = CMD_WR_DEF,
  parameter logic [DATA-1:0] CMD_RD   = CMD_RD_DEF,
  parameter logic [DATA-1:0] ERR_BYTE = ERR_BYTE_DEF,
  parameter int unsigned     RD_TMO   = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [DATA-1:0] RX_P_DATA,
  input  logic            RX_D_VLD,
  input  logic [DATA-1:0] RdData,
  input  logic            RdData_Valid,
  input  logic            TX_Busy,
  output logic            WrEn,
  output logic            RdEn,
  output logic [ADD-1:0]  Address,
  output logic [DATA-1:0] WrData,
  output logic [DATA-1:0] TX_P_DATA,
  output logic            TX_D_VLD
);

  localparam int unsigned CntW = $clog2(RD_TMO + 1);

  state_e          state_q, state_d;
  logic [ADD-1:0]  addr_q, addr_d;
  logic [DATA-1:0] wr_data_q, wr_data_d;
  logic [DATA-1:0] tx_data_q, tx_data_d;
  logic            wr_en_q, wr_en_d;
  logic            rd_en_q, rd_en_d;
  logic            tx_vld_q, tx_vld_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic            in_range;

  assign in_range = upper_bits_zero(32'(RX_P_DATA), ADD);

  // Next-state decode and next values for every registered output
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    tx_vld_d  = 1'b0;
    cnt_d     = cnt_q;
    cnt_inc   = cnt_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_WR) begin
            state_d = StWrAddr;
          end else if (RX_P_DATA == CMD_RD) begin
            state_d = StRdAddr;
          end
        end
      end
      StWrAddr: begin
        if (RX_D_VLD) begin
          if (in_range) begin
            addr_d  = RX_P_DATA[ADD-1:0];
            state_d = StWrData;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StWrData: begin
        if (RX_D_VLD) begin
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = StIdle;
        end
      end
      StRdAddr: begin
        if (RX_D_VLD) begin
          if (in_range) begin
            addr_d  = RX_P_DATA[ADD-1:0];
            rd_en_d = 1'b1;
            cnt_d   = '0;
            state_d = StRdWait;
          end else begin
            tx_data_d = ERR_BYTE;
            state_d   = StTxSend;
          end
        end
      end
      StRdWait: begin
        // Valid is ignored while our own RdEn pulse is still on the bus; that
        // cycle still counts toward the timeout.
        if (!rd_en_q && RdData_Valid) begin
          tx_data_d = RdData;
          state_d   = StTxSend;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntW'(RD_TMO)) begin
            tx_data_d = ERR_BYTE;
            state_d   = StTxSend;
          end
        end
      end
      StTxSend: begin
        if (!TX_Busy) begin
          tx_vld_d = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, timeout counter and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_vld_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      tx_vld_q  <= tx_vld_d;
      cnt_q     <= cnt_d;
    end
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = addr_q;
  assign WrData    = wr_data_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;

endmodule
